// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction-fetch front end
package fetch_pkg;

    localparam int QDEPTH_DEFAULT = 4;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch bundle: instruction-memory port, redirect input and decode handshake
interface fetch_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc4
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc4
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetched {pc, instr} entries with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head_entry
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  last_entry;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_ONE;
            if (do_pop)  head <= head + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail] <= push_entry;
    end

    // Present the head slot, or hold the last presented entry while empty.
    always_comb begin
        head_entry = last_entry;
        if (!empty) head_entry = mem[head];
    end

    // Remember what was last presented so the outputs stay stable while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_entry <= '0;
        else      last_entry <= head_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS fetch front end: PC, imem address, fetch queue, redirect; FETCH_STATS_EN adds fetch/flush counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    logic [31:0]  pc;
    logic         full;
    logic         empty;
    logic         pop;
    logic         push;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign bus.imem_addr = pc;

    // Decode takes the head whenever something is presented and it is ready.
    assign pop  = !empty && bus.out_ready;
    // Redirect suppresses fetch; otherwise fetch whenever the queue can take a word.
    assign push = !bus.redirect_valid && (!full || pop);

    assign push_entry = '{pc: pc, instr: bus.imem_data};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .full       (full),
        .empty      (empty),
        .head_entry (head_entry)
    );

    assign bus.out_valid = !empty;
    assign bus.out_instr = head_entry.instr;
    assign bus.out_pc    = head_entry.pc;
    assign bus.out_pc4   = head_entry.pc + PC_STEP;

    // Program counter: redirect target takes priority, else step after each fetched word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    pc <= RESET_PC;
        else if (bus.redirect_valid) pc <= bus.redirect_pc;
        else if (push)               pc <= pc + PC_STEP;
    end

`ifdef FETCH_STATS_EN
    // Count fetched words and redirects; a redirect cycle never fetches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push)               fetch_count <= fetch_count + 32'd1;
            if (bus.redirect_valid) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
